// File: rtl/frame_sequencer_pkg.sv
// Shared types and defaults for the frame sequencer: state encoding, default lengths and symbols.
package frame_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSync    = 2'd1,
        StPayload = 2'd2,
        StGuard   = 2'd3
    } state_e;

    localparam int unsigned DefSyncLen     = 16;
    localparam int unsigned DefPayloadLen  = 1024;
    localparam int unsigned DefGuardLen    = 4;
    localparam int unsigned DefPilotPeriod = 32;
    localparam logic [15:0] DefSyncPattern = 16'hA5C3;
    localparam logic [3:0]  DefSyncSym1    = 4'hF;
    localparam logic [3:0]  DefSyncSym0    = 4'h0;
    localparam logic [3:0]  DefGuardSym    = 4'h5;
    localparam logic [3:0]  DefPilotSym    = 4'hF;

    // Segment lengths are limited to 1..65535, so the low 16 bits carry the whole value.
    function automatic logic [15:0] len16(input int unsigned len);
        return len[15:0];
    endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Handshake/data bundle between the symbol-path control and the frame sequencer.
interface frame_sequencer_if;
    logic        sym_en;
    logic        start;
    logic        stop;
    logic [3:0]  lfsr_sym;
    logic        lfsr_en;
    logic        lfsr_reload;
    logic [3:0]  sym_out;
    logic        sym_valid;
    logic        frame_start;
    logic        busy;
    logic [15:0] frame_cnt;

    modport master (
        output sym_en, start, stop, lfsr_sym,
        input  lfsr_en, lfsr_reload, sym_out, sym_valid, frame_start, busy, frame_cnt
    );

    modport slave (
        input  sym_en, start, stop, lfsr_sym,
        output lfsr_en, lfsr_reload, sym_out, sym_valid, frame_start, busy, frame_cnt
    );
endinterface

// File: rtl/frame_sequencer_seg_counter.sv
// 16-bit segment counter: enable, synchronous clear (wins over enable), terminal-count flag.
module frame_sequencer_seg_counter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_clr,
    input  logic [15:0] i_len,
    output logic [15:0] o_cnt,
    output logic        o_tc
);
    logic [15:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 16'd0;
        end else if (i_clr) begin
            r_cnt <= 16'd0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_len - 16'd1);
endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: SYNC preamble, LFSR PAYLOAD, GUARD, advancing on the symbol strobe.
// Optional build macro PILOT_INSERT_EN replaces every PILOT_PERIOD-th payload slot by PILOT_SYM.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int unsigned          SYNC_LEN          = DefSyncLen,
    parameter int unsigned          PAYLOAD_LEN       = DefPayloadLen,
    parameter int unsigned          GUARD_LEN         = DefGuardLen,
    parameter logic [SYNC_LEN-1:0]  SYNC_PATTERN      = SYNC_LEN'(DefSyncPattern),
    parameter logic [3:0]           SYNC_SYM_1        = DefSyncSym1,
    parameter logic [3:0]           SYNC_SYM_0        = DefSyncSym0,
    parameter logic [3:0]           GUARD_SYM         = DefGuardSym,
    parameter bit                   RESEED_EACH_FRAME = 1'b1,
    parameter int unsigned          PILOT_PERIOD      = DefPilotPeriod,
    parameter logic [3:0]           PILOT_SYM         = DefPilotSym
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    frame_sequencer_if.slave  io_seq
);
    localparam logic [15:0] SyncLen16    = len16(SYNC_LEN);
    localparam logic [15:0] PayloadLen16 = len16(PAYLOAD_LEN);
    localparam logic [15:0] GuardLen16   = len16(GUARD_LEN);

    state_e              r_state, w_state_d;
    logic                r_start_pend, w_start_pend_d;
    logic                r_stop_pend, w_stop_pend_d;
    logic [3:0]          r_sym_out, w_sym_out_d;
    logic                r_sym_valid, w_sym_valid_d;
    logic                r_frame_start, w_frame_start_d;
    logic [15:0]         r_frame_cnt, w_frame_cnt_d;
    logic [15:0]         w_seg_cnt, w_seg_len;
    logic                w_seg_tc;
    logic                w_in_idle, w_in_payload;
    logic                w_pilot_slot;
    logic [SYNC_LEN-1:0] w_pat_shift;

    assign w_in_idle    = (r_state == StIdle);
    assign w_in_payload = (r_state == StPayload);
    assign w_pat_shift  = SYNC_PATTERN >> w_seg_cnt;

    always_comb begin
        case (r_state)
            StSync:    w_seg_len = SyncLen16;
            StPayload: w_seg_len = PayloadLen16;
            StGuard:   w_seg_len = GuardLen16;
            default:   w_seg_len = 16'd1;
        endcase
    end

    // Cleared on every strobe in IDLE and at each segment's last symbol.
    frame_sequencer_seg_counter u_seg_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_reset_n),
        .i_en    (io_seq.sym_en),
        .i_clr   (io_seq.sym_en & (w_in_idle | w_seg_tc)),
        .i_len   (w_seg_len),
        .o_cnt   (w_seg_cnt),
        .o_tc    (w_seg_tc)
    );

`ifdef PILOT_INSERT_EN
    localparam logic [15:0] PilotLen16 = len16(PILOT_PERIOD);
    logic [15:0] w_pilot_cnt;
    logic        w_pilot_tc;
    logic        w_unused_pilot_cnt;

    // Held at zero outside PAYLOAD so every payload starts a fresh pilot period.
    frame_sequencer_seg_counter u_pilot_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_reset_n),
        .i_en    (io_seq.sym_en & w_in_payload),
        .i_clr   (io_seq.sym_en & (~w_in_payload | w_pilot_tc)),
        .i_len   (PilotLen16),
        .o_cnt   (w_pilot_cnt),
        .o_tc    (w_pilot_tc)
    );

    assign w_unused_pilot_cnt = ^w_pilot_cnt;
    assign w_pilot_slot       = w_in_payload & w_pilot_tc;
`else
    logic w_unused_pilot_cfg;
    assign w_unused_pilot_cfg = ^PILOT_PERIOD;
    assign w_pilot_slot       = 1'b0;
`endif

    always_comb begin
        w_state_d       = r_state;
        w_start_pend_d  = r_start_pend | io_seq.start;
        w_stop_pend_d   = r_stop_pend | io_seq.stop;
        w_sym_out_d     = r_sym_out;
        w_sym_valid_d   = r_sym_valid;
        w_frame_start_d = 1'b0;
        w_frame_cnt_d   = r_frame_cnt;
        if (io_seq.sym_en) begin
            unique case (r_state)
                StIdle: begin
                    w_sym_out_d   = 4'h0;
                    w_sym_valid_d = 1'b0;
                    if (r_start_pend && r_stop_pend) begin
                        w_start_pend_d = io_seq.start;
                        w_stop_pend_d  = io_seq.stop;
                    end else if (r_start_pend) begin
                        w_state_d      = StSync;
                        w_start_pend_d = io_seq.start;
                    end
                end
                StSync: begin
                    w_sym_out_d     = w_pat_shift[0] ? SYNC_SYM_1 : SYNC_SYM_0;
                    w_sym_valid_d   = 1'b1;
                    w_frame_start_d = (w_seg_cnt == 16'd0);
                    if (w_seg_tc) w_state_d = StPayload;
                end
                StPayload: begin
                    w_sym_out_d   = w_pilot_slot ? PILOT_SYM : io_seq.lfsr_sym;
                    w_sym_valid_d = 1'b1;
                    if (w_seg_tc) w_state_d = StGuard;
                end
                StGuard: begin
                    w_sym_out_d   = GUARD_SYM;
                    w_sym_valid_d = 1'b1;
                    if (w_seg_tc) begin
                        w_frame_cnt_d = r_frame_cnt + 16'd1;
                        if (r_stop_pend) begin
                            w_state_d     = StIdle;
                            w_stop_pend_d = io_seq.stop;
                        end else begin
                            w_state_d = StSync;
                        end
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_start_pend  <= 1'b0;
            r_stop_pend   <= 1'b0;
            r_sym_out     <= 4'h0;
            r_sym_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= 16'd0;
        end else begin
            r_state       <= w_state_d;
            r_start_pend  <= w_start_pend_d;
            r_stop_pend   <= w_stop_pend_d;
            r_sym_out     <= w_sym_out_d;
            r_sym_valid   <= w_sym_valid_d;
            r_frame_start <= w_frame_start_d;
            r_frame_cnt   <= w_frame_cnt_d;
        end
    end

    // The mapper captures lfsr_sym on this same edge, before the LFSR steps.
    assign io_seq.lfsr_en     = io_seq.sym_en & w_in_payload & ~w_pilot_slot;
    assign io_seq.lfsr_reload = io_seq.sym_en & RESEED_EACH_FRAME & (r_state == StSync) & w_seg_tc;
    assign io_seq.sym_out     = r_sym_out;
    assign io_seq.sym_valid   = r_sym_valid;
    assign io_seq.frame_start = r_frame_start;
    assign io_seq.busy        = ~w_in_idle;
    assign io_seq.frame_cnt   = r_frame_cnt;
endmodule
